jump_target_unit: RTL and testbench

Registered jump-target unit for the ID/EX boundary of the pipelined MIPS core. It forms J/JAL pseudo-direct targets from a parametrised PC and index width. It keeps a circular return-address stack (RAS) that is pushed by JAL and popped by JR through `$ra`, and it flags JR mispredictions. Outputs are registered and follow the pipeline stall/flush protocol, so fetch steering and hazard logic see a stable target for one stage.

---
 rtl/mips_pkg.sv | 15 +
 rtl/return_addr_stack.sv | 73 +++++++
 rtl/jump_target_unit.sv | 136 +++++++++++++
 tb/tb_jump_target_unit.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: jump-kind encodings and architectural register numbers.
package mips_pkg;

    // Jump kind carried from decode into the jump-target unit.
    typedef enum logic [1:0] {
        JK_NONE = 2'b00,
        JK_J    = 2'b01,
        JK_JAL  = 2'b10,
        JK_JR   = 2'b11
    } jump_kind_e;

    // Link register written by JAL and read by the function-return idiom "jr $ra".
    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: JAL pushes, "jr $ra" pops.
// When full, a push overwrites the oldest entry and the count saturates at the depth.
module return_addr_stack #(
    parameter int ADDR_WIDTH = 32,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  hold_i,
    input  logic [ADDR_WIDTH-1:0] push_data_i,
    output logic [ADDR_WIDTH-1:0] pop_data_o,
    output logic                  empty_o,
    output logic                  full_o
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

    // top_q points at the next free slot; the most recent entry sits just below it.
    logic [PTR_W-1:0]      top_q;
    logic [PTR_W-1:0]      top_d;
    logic [PTR_W-1:0]      below_top;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [ADDR_WIDTH-1:0] entries_q [RAS_DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign below_top  = top_q - PTR_W'(1);
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == DEPTH_CNT);
    assign pop_data_o = entries_q[below_top];

    // A push wins over a pop if both are ever requested; a pop on an empty stack is ignored.
    assign do_push = push_i & ~hold_i;
    assign do_pop  = pop_i & ~hold_i & ~push_i & ~empty_o;

    // Next top pointer and occupancy count.
    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        if (do_push) begin
            top_d = top_q + PTR_W'(1);
            if (!full_o) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (do_pop) begin
            top_d   = below_top;
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer, count and entry storage; reset wipes every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            top_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
            if (do_push) begin
                entries_q[top_q] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/jump_target_unit.sv
// Registered jump-target unit at the ID/EX boundary: forms J/JAL pseudo-direct targets,
// passes JR targets through, and predicts/checks "jr $ra" with a return-address stack.
module jump_target_unit
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = 26,
    parameter int RAS_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic                   valid_i,
    input  logic [1:0]             kind_i,
    input  logic [INDEX_WIDTH-1:0] index_i,
    input  logic [ADDR_WIDTH-1:0]  pc4_i,
    input  logic [ADDR_WIDTH-1:0]  rs_value_i,
    input  logic                   rs_is_ra_i,
    output logic                   target_valid_o,
    output logic [ADDR_WIDTH-1:0]  target_o,
    output logic [ADDR_WIDTH-1:0]  link_o,
    output logic [ADDR_WIDTH-1:0]  ras_pred_o,
    output logic                   ras_mispredict_o,
    output logic                   ras_empty_o,
    output logic                   ras_full_o
);

    jump_kind_e            kind;
    logic                  accept;
    logic                  ras_push;
    logic                  ras_pop;
    logic                  ras_hold;
    logic [ADDR_WIDTH-1:0] ras_top;
    logic [ADDR_WIDTH-1:0] pseudo_target;

    logic                  target_valid_q, target_valid_d;
    logic [ADDR_WIDTH-1:0] target_q,       target_d;
    logic [ADDR_WIDTH-1:0] link_q,         link_d;
    logic [ADDR_WIDTH-1:0] ras_pred_q,     ras_pred_d;
    logic                  mispredict_q,   mispredict_d;

    assign kind = jump_kind_e'(kind_i);

    // Pseudo-direct target keeps the PC's upper segment; if the index fills the whole
    // address there are no upper bits left to keep.
    generate
        if (ADDR_WIDTH > INDEX_WIDTH + 2) begin : g_upper
            assign pseudo_target = {pc4_i[ADDR_WIDTH-1:INDEX_WIDTH+2], index_i, 2'b00};
        end else begin : g_exact
            assign pseudo_target = {index_i, 2'b00};
        end
    endgenerate

    assign accept   = valid_i & ~stall_i & ~flush_i & (kind != JK_NONE);
    assign ras_push = accept & (kind == JK_JAL);
    assign ras_pop  = accept & (kind == JK_JR) & rs_is_ra_i & ~ras_empty_o;
    assign ras_hold = stall_i | flush_i;

    return_addr_stack #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAS_DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .hold_i      (ras_hold),
        .push_data_i (pc4_i),
        .pop_data_o  (ras_top),
        .empty_o     (ras_empty_o),
        .full_o      (ras_full_o)
    );

    // Next output values: flush invalidates, stall holds, accept loads, idle invalidates.
    always_comb begin
        target_valid_d = target_valid_q;
        target_d       = target_q;
        link_d         = link_q;
        ras_pred_d     = ras_pred_q;
        mispredict_d   = mispredict_q;
        if (flush_i) begin
            target_valid_d = 1'b0;
            mispredict_d   = 1'b0;
        end else if (stall_i) begin
            target_valid_d = target_valid_q;
        end else if (accept) begin
            target_valid_d = 1'b1;
            mispredict_d   = 1'b0;
            case (kind)
                JK_J: begin
                    target_d = pseudo_target;
                end
                JK_JAL: begin
                    target_d = pseudo_target;
                    link_d   = pc4_i;
                end
                JK_JR: begin
                    target_d     = rs_value_i;
                    ras_pred_d   = ras_pop ? ras_top : '0;
                    mispredict_d = ras_pop && (ras_top != rs_value_i);
                end
                default: begin
                    target_d = target_q;
                end
            endcase
        end else begin
            target_valid_d = 1'b0;
            mispredict_d   = 1'b0;
        end
    end

    // Output registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            target_valid_q <= 1'b0;
            target_q       <= '0;
            link_q         <= '0;
            ras_pred_q     <= '0;
            mispredict_q   <= 1'b0;
        end else begin
            target_valid_q <= target_valid_d;
            target_q       <= target_d;
            link_q         <= link_d;
            ras_pred_q     <= ras_pred_d;
            mispredict_q   <= mispredict_d;
        end
    end

    assign target_valid_o   = target_valid_q;
    assign target_o         = target_q;
    assign link_o           = link_q;
    assign ras_pred_o       = ras_pred_q;
    assign ras_mispredict_o = mispredict_q;

endmodule

// File: tb/tb_jump_target_unit.sv
// Self-checking bench for jump_target_unit with a queue-based reference model.
module tb_jump_target_unit;
    import mips_pkg::*;

    localparam int AW    = 32;
    localparam int IW    = 26;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          stallIn;
    logic          flushIn;
    logic          validIn;
    logic [1:0]    kindIn;
    logic [IW-1:0] indexIn;
    logic [AW-1:0] pc4In;
    logic [AW-1:0] rsIn;
    logic          rsIsRaIn;

    logic          targetValid;
    logic [AW-1:0] target;
    logic [AW-1:0] link;
    logic [AW-1:0] rasPred;
    logic          rasMisp;
    logic          rasEmpty;
    logic          rasFull;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state.
    logic [AW-1:0] rasModel[$];
    logic          mValid;
    logic [AW-1:0] mTarget;
    logic [AW-1:0] mLink;
    logic [AW-1:0] mPred;
    logic          mMisp;

    always #5 clk = ~clk;

    jump_target_unit #(
        .ADDR_WIDTH  (AW),
        .INDEX_WIDTH (IW),
        .RAS_DEPTH   (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_i          (stallIn),
        .flush_i          (flushIn),
        .valid_i          (validIn),
        .kind_i           (kindIn),
        .index_i          (indexIn),
        .pc4_i            (pc4In),
        .rs_value_i       (rsIn),
        .rs_is_ra_i       (rsIsRaIn),
        .target_valid_o   (targetValid),
        .target_o         (target),
        .link_o           (link),
        .ras_pred_o       (rasPred),
        .ras_mispredict_o (rasMisp),
        .ras_empty_o      (rasEmpty),
        .ras_full_o       (rasFull)
    );

    function automatic logic [AW-1:0] pseudoTarget(input logic [AW-1:0] pc4, input logic [IW-1:0] idx);
        return (pc4 & 32'hF000_0000) | ({6'd0, idx} << 2);
    endfunction

    function automatic logic [99:0] dutVec();
        return {targetValid, target, link, rasPred, rasMisp, rasEmpty, rasFull};
    endfunction

    function automatic logic [99:0] modelVec();
        return {mValid, mTarget, mLink, mPred, mMisp, (rasModel.size() == 0), (rasModel.size() == DEPTH)};
    endfunction

    // Behavioural model of one rising edge, using the inputs present before the edge.
    task automatic modelEdge();
        if (reset) begin
            rasModel.delete();
            mValid = 0; mTarget = 0; mLink = 0; mPred = 0; mMisp = 0;
        end else if (flushIn) begin
            mValid = 0; mMisp = 0;
        end else if (stallIn) begin
            mValid = mValid;
        end else if (validIn && kindIn != 2'b00) begin
            mValid = 1;
            mMisp  = 0;
            if (kindIn == 2'b01) begin
                mTarget = pseudoTarget(pc4In, indexIn);
            end else if (kindIn == 2'b10) begin
                mTarget = pseudoTarget(pc4In, indexIn);
                mLink   = pc4In;
                rasModel.push_back(pc4In);
                if (rasModel.size() > DEPTH) void'(rasModel.pop_front());
            end else begin
                mTarget = rsIn;
                if (rsIsRaIn && rasModel.size() > 0) begin
                    mPred = rasModel.pop_back();
                    mMisp = (mPred != rsIn);
                end else begin
                    mPred = 0;
                end
            end
        end else begin
            mValid = 0; mMisp = 0;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] k, input logic [IW-1:0] idx,
                                 input logic [AW-1:0] pc, input logic [AW-1:0] rs, input logic ra,
                                 input logic st, input logic fl);
        validIn = v; kindIn = k; indexIn = idx; pc4In = pc; rsIn = rs; rsIsRaIn = ra;
        stallIn = st; flushIn = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic doReset();
        applyStimulus(0, JK_NONE, 0, 0, 0, 0, 0, 0);
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        applyStimulus(0, JK_NONE, 0, 0, 0, 0, 0, 0);
        reset = 1;
        tick();
        tick();
        reset = 0;
        testsRun++;
        if (dutVec() !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL reset_values got %h expected %h", dutVec(), {1'b0, 96'h0, 1'b0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_j();
        applyStimulus(1, JK_J, 26'h010_0008, 32'h0040_0010, 0, 0, 0, 0);
        tick();
        testsRun++;
        if ({targetValid, target, rasEmpty} !== {1'b1, 32'h0040_0020, 1'b1}) begin
            testsFailed++;
            $display("[TB] FAIL j_target got %b/%h/%b expected 1/00400020/1", targetValid, target, rasEmpty);
        end
        applyStimulus(0, JK_NONE, 0, 0, 0, 0, 0, 0);
        tick();
        testsRun++;
        if (dutVec() !== modelVec() || targetValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL j_idle got %h expected %h", dutVec(), modelVec());
        end
    endtask

    task automatic test_jal_jr();
        applyStimulus(1, JK_JAL, 26'h000_1234, 32'h0040_0104, 0, 0, 0, 0);
        tick();
        testsRun++;
        if ({targetValid, link, rasEmpty} !== {1'b1, 32'h0040_0104, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL jal_link got %b/%h/%b expected 1/00400104/0", targetValid, link, rasEmpty);
        end
        applyStimulus(1, JK_JR, 0, 0, 32'h0040_0104, 1, 0, 0);
        tick();
        testsRun++;
        if ({target, rasPred, rasMisp, rasEmpty} !== {32'h0040_0104, 32'h0040_0104, 1'b0, 1'b1}) begin
            testsFailed++;
            $display("[TB] FAIL jr_pop got %h/%h/%b/%b expected 00400104/00400104/0/1", target, rasPred, rasMisp, rasEmpty);
        end
    endtask

    task automatic test_overflow();
        logic [AW-1:0] expPops [5];
        expPops = '{32'h50, 32'h40, 32'h30, 32'h20, 32'h0};
        doReset();
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1, JK_JAL, IW'($urandom), AW'(i * 16), 0, 0, 0, 0);
            tick();
        end
        testsRun++;
        if ({rasFull, rasEmpty} !== 2'b10 || dutVec() !== modelVec()) begin
            testsFailed++;
            $display("[TB] FAIL overflow_full got %h expected %h", dutVec(), modelVec());
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, JK_JR, 0, 0, expPops[i], 1, 0, 0);
            tick();
            testsRun++;
            if (rasPred !== expPops[i] || rasMisp !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL overflow_pop%0d got %h/%b expected %h/0", i, rasPred, rasMisp, expPops[i]);
            end
        end
    endtask

    task automatic test_mispredict();
        doReset();
        applyStimulus(1, JK_JAL, 0, 32'h200, 0, 0, 0, 0);
        tick();
        applyStimulus(1, JK_JR, 0, 0, 32'h300, 1, 0, 0);
        tick();
        testsRun++;
        if ({target, rasPred, rasMisp} !== {32'h300, 32'h200, 1'b1}) begin
            testsFailed++;
            $display("[TB] FAIL mispredict got %h/%h/%b expected 00000300/00000200/1", target, rasPred, rasMisp);
        end
        applyStimulus(0, JK_NONE, 0, 0, 0, 0, 0, 0);
        tick();
        testsRun++;
        if (rasMisp !== 1'b0 || rasPred !== 32'h200) begin
            testsFailed++;
            $display("[TB] FAIL mispredict_clear got %b/%h expected 0/00000200", rasMisp, rasPred);
        end
    endtask

    task automatic test_stall_flush();
        doReset();
        applyStimulus(1, JK_JAL, 26'h40, 32'h1000, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, JK_JAL, 26'h80, 32'h2000, 0, 0, 1, 0);
            tick();
            testsRun++;
            if ({targetValid, target, link, rasEmpty, rasFull} !== {1'b1, 32'h100, 32'h1000, 1'b0, 1'b0}) begin
                testsFailed++;
                $display("[TB] FAIL stall_hold%0d got %b/%h/%h/%b expected 1/00000100/00001000/0", i, targetValid, target, link, rasEmpty);
            end
        end
        applyStimulus(1, JK_JAL, 26'h80, 32'h2000, 0, 0, 1, 1);
        tick();
        testsRun++;
        if ({targetValid, link} !== {1'b0, 32'h1000}) begin
            testsFailed++;
            $display("[TB] FAIL flush_stall got %b/%h expected 0/00001000", targetValid, link);
        end
        applyStimulus(1, JK_JR, 0, 0, 32'h1000, 1, 0, 0);
        tick();
        testsRun++;
        if ({rasPred, rasMisp, rasEmpty} !== {32'h1000, 1'b0, 1'b1}) begin
            testsFailed++;
            $display("[TB] FAIL flush_no_push got %h/%b/%b expected 00001000/0/1", rasPred, rasMisp, rasEmpty);
        end
    endtask

    task automatic test_reset_mid();
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, JK_JAL, IW'($urandom), AW'(32'h4000 + i * 4), 0, 0, 0, 0);
            tick();
        end
        applyStimulus(1, JK_JAL, 26'h55, 32'h9000, 0, 0, 0, 0);
        reset = 1;
        tick();
        reset = 0;
        testsRun++;
        if (dutVec() !== {1'b0, 96'h0, 1'b0, 1'b1, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid got %h expected %h", dutVec(), {1'b0, 96'h0, 1'b0, 1'b1, 1'b0});
        end
        applyStimulus(1, JK_JR, 0, 0, 32'h4008, 1, 0, 0);
        tick();
        testsRun++;
        if ({target, rasPred, rasMisp, rasEmpty} !== {32'h4008, 32'h0, 1'b0, 1'b1}) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_jr got %h/%h/%b/%b expected 00004008/00000000/0/1", target, rasPred, rasMisp, rasEmpty);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] rs;
        for (int n = 0; n < 400; n++) begin
            rs = $urandom;
            if (rasModel.size() > 0 && $urandom_range(0, 1) == 1) rs = rasModel[$];
            applyStimulus($urandom_range(0, 9) != 0, 2'($urandom), IW'($urandom), $urandom, rs,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 63) == 0);
            tick();
            testsRun++;
            if (dutVec() !== modelVec()) begin
                testsFailed++;
                $display("[TB] FAIL random%0d got %h expected %h", n, dutVec(), modelVec());
            end
        end
        reset = 0;
    endtask

    task automatic test_back_to_back();
        doReset();
        for (int n = 0; n < 40; n++) begin
            applyStimulus(1, JK_JAL, IW'($urandom), $urandom, 0, 0, 0, 0);
            tick();
            applyStimulus(1, JK_JR, 0, 0, (n % 3 == 0) ? 32'hDEAD_0000 : pc4In, 1, 0, 0);
            tick();
            testsRun++;
            if (dutVec() !== modelVec()) begin
                testsFailed++;
                $display("[TB] FAIL back_to_back%0d got %h expected %h", n, dutVec(), modelVec());
            end
        end
    endtask

    initial begin
        reset = 1;
        applyStimulus(0, JK_NONE, 0, 0, 0, 0, 0, 0);
        mValid = 0; mTarget = 0; mLink = 0; mPred = 0; mMisp = 0;
        test_reset();
        test_j();
        test_jal_jr();
        test_overflow();
        test_mispredict();
        test_stall_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
